updown_mod_counter: RTL and testbench
=====================================

UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
- REQ-001: Parameter W SHALL be the counter width in bits; default 4; legal range 2..16.
- REQ-002: Parameter MOD SHALL be the count modulus (states 0..MOD-1); default 16; legal range 2..2^W.
- REQ-003: Parameter SAT SHALL select the limit mode: default 0 (0 = wrap around, 1 = saturate at limits).
- REQ-004: CLK  input  1  SHALL be the single clock; all state SHALL change on its rising edge.
- REQ-005: CLR  input  1  SHALL be the asynchronous, active-high reset.
- REQ-006: EN  input  1  SHALL be the count enable; the counter holds when EN=0.
- REQ-007: DIR  input  1  SHALL be the counting direction: 0 = up, 1 = down.
- REQ-008: LD  input  1  SHALL be the synchronous parallel-load strobe.
- REQ-009: D  input  W  SHALL be the parallel-load value.
- REQ-010: Q  output  W  SHALL be the registered counter state.
- REQ-011: TC  output  1  SHALL be the combinational terminal-count flag.
- REQ-012: WRAP  output  1  SHALL be a registered one-cycle pulse indicating that a wrap occurred.
- REQ-013: SATF  output  1  SHALL be a registered sticky flag indicating that a count was blocked at a limit.

Function
- REQ-014: Priority at each rising CLK edge SHALL be: LD first, then EN, then hold.
- REQ-015: When LD=1 and D<MOD, Q SHALL become D on the next edge; if D>=MOD, Q SHALL become MOD-1 (clamp).
- REQ-016: LD=1 SHALL clear SATF and force WRAP=0 on the same edge, regardless of EN.
- REQ-017: When EN=1 and LD=0 with DIR=0 and Q<MOD-1, Q SHALL increment by 1.
- REQ-018: When EN=1 and LD=0 with DIR=1 and Q>0, Q SHALL decrement by 1.
- REQ-019: When counting up at Q=MOD-1 with SAT=0, Q SHALL become 0 and WRAP SHALL be 1 for exactly the following cycle.
- REQ-020: When counting down at Q=0 with SAT=0, Q SHALL become MOD-1 and WRAP SHALL be 1 for exactly the following cycle.
- REQ-021: With SAT=1, a count beyond either limit SHALL leave Q unchanged, set SATF=1, and keep WRAP at 0.
- REQ-022: SATF SHALL remain 1 until LD or CLR; WRAP SHALL be 0 on any edge where no wrap occurs.
- REQ-023: TC SHALL equal EN & ~LD & ((~DIR & Q==MOD-1) | (DIR & Q==0)).
- REQ-024: A DIR change SHALL take effect on the very next enabled edge, with no dead cycle.
- REQ-025: Q SHALL never hold a value >= MOD after reset or after any edge.
- REQ-026: All arithmetic SHALL be W bits unsigned; the modulus compare SHALL be exact for MOD=2^W, where wrap equals natural overflow.
- REQ-027: Latency from any input to Q, WRAP or SATF SHALL be one clock edge; TC SHALL have zero-cycle latency.

Reset
- REQ-028: CLR=1 SHALL immediately, without waiting for CLK, force Q=0, WRAP=0 and SATF=0.
- REQ-029: While CLR=1, the block SHALL ignore LD and EN.
- REQ-030: After CLR deasserts, the first active edge SHALL act from Q=0.
- REQ-031: CLR asserted mid-count or mid-WRAP-pulse SHALL abort the operation with no residual pulse.

Verification
- REQ-032: Up-wrap, W=3 MOD=8 SAT=0: EN=1, DIR=0 from reset for 9 edges -> Q = 1..7, 0, 1; WRAP high only in the cycle after 7->0; TC high while Q=7.
- REQ-033: Down-wrap and direction change, W=3 MOD=8: count up to 3, set DIR=1 -> next edges give 2, 1, 0, 7; WRAP pulses once after 0->7.
- REQ-034: Modulus, W=4 MOD=10 SAT=0: from LD D=8, count up -> 9, 0, 1; then LD D=12 -> Q=9 (clamped).
- REQ-035: Saturation, W=4 MOD=10 SAT=1: at Q=9 with DIR=0 for 3 edges -> Q stays 9 and SATF=1 with WRAP=0; then DIR=1 at Q=0 -> Q stays 0; then LD D=4 -> Q=4 and SATF=0.
- REQ-036: Priority and hold: with LD=1, EN=1, D=5 -> Q=5; with EN=0 for 4 edges -> Q stays 5 and TC=0.
- REQ-037: Asynchronous reset: CLR pulse between edges while Q=6 -> Q=0 before the next CLK edge; WRAP and SATF read 0.

Source files
------------

// File: rtl/updown_mod_counter.sv
// Modulo-MOD up/down counter with parallel load, wrap or saturate at the limits,
// a one-cycle wrap pulse and a sticky saturation flag.
module updown_mod_counter #(
  parameter int W   = 4,
  parameter int MOD = 16,
  parameter int SAT = 0
) (
  input  logic         CLK,
  input  logic         CLR,
  input  logic         EN,
  input  logic         DIR,
  input  logic         LD,
  input  logic [W-1:0] D,
  output logic [W-1:0] Q,
  output logic         TC,
  output logic         WRAP,
  output logic         SATF
);

  // For MOD == 2**W the top value is all ones and the load clamp never fires.
  localparam logic [W-1:0] MAXV = W'(MOD - 1);

  logic         at_max;
  logic         at_min;
  logic [W-1:0] q_nxt;
  logic         wrap_nxt;
  logic         satf_nxt;

  assign at_max = (Q == MAXV);
  assign at_min = (Q == '0);
  assign TC     = EN & ~LD & ((~DIR & at_max) | (DIR & at_min));

  always_comb begin
    q_nxt    = Q;
    wrap_nxt = 1'b0;
    satf_nxt = SATF;
    if (LD) begin
      q_nxt    = (D > MAXV) ? MAXV : D;
      satf_nxt = 1'b0;
    end else if (EN) begin
      if (!DIR) begin
        if (!at_max) begin
          q_nxt = Q + W'(1);
        end else if (SAT != 0) begin
          satf_nxt = 1'b1;
        end else begin
          q_nxt    = '0;
          wrap_nxt = 1'b1;
        end
      end else begin
        if (!at_min) begin
          q_nxt = Q - W'(1);
        end else if (SAT != 0) begin
          satf_nxt = 1'b1;
        end else begin
          q_nxt    = MAXV;
          wrap_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      Q    <= '0;
      WRAP <= 1'b0;
      SATF <= 1'b0;
    end else begin
      Q    <= q_nxt;
      WRAP <= wrap_nxt;
      SATF <= satf_nxt;
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: four parameterisations driven by directed vectors,
// hand-written reset sequences and random stimulus against an arithmetic model.
module tb_updown_mod_counter;

  logic       CLK;
  logic [3:0] clr, en, dir, ld;
  logic [3:0] d [4];

  logic [2:0] q0;
  logic [3:0] q1, q2, q3;
  logic       tc0, tc1, tc2, tc3;
  logic       wr0, wr1, wr2, wr3;
  logic       sf0, sf1, sf2, sf3;

  updown_mod_counter #(.W(3), .MOD(8), .SAT(0)) u0 (
    .CLK(CLK), .CLR(clr[0]), .EN(en[0]), .DIR(dir[0]), .LD(ld[0]), .D(d[0][2:0]),
    .Q(q0), .TC(tc0), .WRAP(wr0), .SATF(sf0));
  updown_mod_counter #(.W(4), .MOD(10), .SAT(0)) u1 (
    .CLK(CLK), .CLR(clr[1]), .EN(en[1]), .DIR(dir[1]), .LD(ld[1]), .D(d[1]),
    .Q(q1), .TC(tc1), .WRAP(wr1), .SATF(sf1));
  updown_mod_counter #(.W(4), .MOD(10), .SAT(1)) u2 (
    .CLK(CLK), .CLR(clr[2]), .EN(en[2]), .DIR(dir[2]), .LD(ld[2]), .D(d[2]),
    .Q(q2), .TC(tc2), .WRAP(wr2), .SATF(sf2));
  updown_mod_counter #(.W(4), .MOD(16), .SAT(0)) u3 (
    .CLK(CLK), .CLR(clr[3]), .EN(en[3]), .DIR(dir[3]), .LD(ld[3]), .D(d[3]),
    .Q(q3), .TC(tc3), .WRAP(wr3), .SATF(sf3));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int ncomp = 0;
  int nfail = 0;

  int pw   [4] = '{3, 4, 4, 4};
  int pmod [4] = '{8, 10, 10, 16};
  int psat [4] = '{0, 0, 1, 0};
  int mq   [4];
  int mwrap[4];
  int msatf[4];

  function automatic int getq(int i);
    case (i)
      0: return int'(q0);
      1: return int'(q1);
      2: return int'(q2);
      default: return int'(q3);
    endcase
  endfunction

  function automatic int gettc(int i);
    case (i)
      0: return int'(tc0);
      1: return int'(tc1);
      2: return int'(tc2);
      default: return int'(tc3);
    endcase
  endfunction

  function automatic int getwrap(int i);
    case (i)
      0: return int'(wr0);
      1: return int'(wr1);
      2: return int'(wr2);
      default: return int'(wr3);
    endcase
  endfunction

  function automatic int getsatf(int i);
    case (i)
      0: return int'(sf0);
      1: return int'(sf1);
      2: return int'(sf2);
      default: return int'(sf3);
    endcase
  endfunction

  task automatic check(string name, int i, int act, int exp);
    ncomp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s inst%0d @%0t: got %0d expected %0d", name, i, $time, act, exp);
    end
  endtask

  // Clear is asynchronous, so the model state is dropped the moment it is raised.
  task automatic set_clr(int i, bit v);
    clr[i] = v;
    if (v) begin
      mq[i] = 0; mwrap[i] = 0; msatf[i] = 0;
    end
  endtask

  task automatic model_step(int i);
    int dv, nxt;
    if (clr[i]) begin
      mq[i] = 0; mwrap[i] = 0; msatf[i] = 0;
    end else if (ld[i]) begin
      dv = int'(d[i]) % (1 << pw[i]);
      mq[i] = (dv >= pmod[i]) ? pmod[i] - 1 : dv;
      mwrap[i] = 0; msatf[i] = 0;
    end else if (en[i]) begin
      nxt = dir[i] ? mq[i] - 1 : mq[i] + 1;
      if (nxt < 0 || nxt >= pmod[i]) begin
        mwrap[i] = 0;
        if (psat[i] != 0) msatf[i] = 1;
        else begin
          mq[i] = (nxt + pmod[i]) % pmod[i];
          mwrap[i] = 1;
        end
      end else begin
        mq[i] = nxt; mwrap[i] = 0;
      end
    end else begin
      mwrap[i] = 0;
    end
  endtask

  function automatic int model_tc(int i);
    return int'(en[i] & ~ld[i] &
      ((~dir[i] & (mq[i] == pmod[i] - 1)) | (dir[i] & (mq[i] == 0))));
  endfunction

  task automatic tick();
    @(posedge CLK);
    for (int i = 0; i < 4; i++) model_step(i);
    #1;
  endtask

  task automatic idle();
    en = '0; ld = '0; dir = '0;
    for (int i = 0; i < 4; i++) d[i] = '0;
  endtask

  typedef struct {
    int inst; bit ld; bit en; bit dir; int d;
    int tc; int q; int wrap; int satf;
  } vec_t;
  vec_t vq[$];

  function automatic void add(int inst, bit l, bit e, bit r, int dd,
                              int tc, int q, int w, int s);
    vec_t v;
    v.inst = inst; v.ld = l; v.en = e; v.dir = r; v.d = dd;
    v.tc = tc; v.q = q; v.wrap = w; v.satf = s;
    vq.push_back(v);
  endfunction

  initial begin
    // W=3 MOD=8: up-wrap, then direction change and down-wrap
    for (int k = 1; k <= 7; k++) add(0, 0, 1, 0, 0, 0, k, 0, 0);
    add(0, 0, 1, 0, 0, 1, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 2, 0, 0);
    add(0, 0, 1, 0, 0, 0, 3, 0, 0);
    add(0, 0, 1, 1, 0, 0, 2, 0, 0);
    add(0, 0, 1, 1, 0, 0, 1, 0, 0);
    add(0, 0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 1, 7, 1, 0);
    add(0, 0, 0, 1, 0, 0, 7, 0, 0);
    // W=4 MOD=10 wrapping: modulus and load clamp
    add(1, 1, 0, 0, 8, 0, 8, 0, 0);
    add(1, 0, 1, 0, 0, 0, 9, 0, 0);
    add(1, 0, 1, 0, 0, 1, 0, 1, 0);
    add(1, 0, 1, 0, 0, 0, 1, 0, 0);
    add(1, 1, 1, 0, 12, 0, 9, 0, 0);
    add(1, 1, 1, 0, 3, 0, 3, 0, 0);
    // W=4 MOD=10 saturating
    add(2, 1, 0, 0, 9, 0, 9, 0, 0);
    for (int k = 0; k < 3; k++) add(2, 0, 1, 0, 0, 1, 9, 0, 1);
    for (int k = 8; k >= 0; k--) add(2, 0, 1, 1, 0, 0, k, 0, 1);
    add(2, 0, 1, 1, 0, 1, 0, 0, 1);
    add(2, 0, 1, 1, 0, 1, 0, 0, 1);
    add(2, 1, 1, 1, 4, 0, 4, 0, 0);
    // W=4 MOD=16: load priority, hold, natural overflow
    add(3, 1, 1, 0, 5, 0, 5, 0, 0);
    for (int k = 0; k < 4; k++) add(3, 0, 0, k % 2, 0, 0, 5, 0, 0);
    add(3, 1, 0, 0, 15, 0, 15, 0, 0);
    add(3, 0, 1, 0, 0, 1, 0, 1, 0);
    add(3, 0, 1, 1, 0, 1, 15, 1, 0);
    add(3, 0, 1, 0, 0, 1, 0, 1, 0);

    idle();
    for (int i = 0; i < 4; i++) set_clr(i, 1'b1);
    #3;
    for (int i = 0; i < 4; i++) begin
      check("reset_q", i, getq(i), 0);
      check("reset_wrap", i, getwrap(i), 0);
      check("reset_satf", i, getsatf(i), 0);
    end
    tick();
    for (int i = 0; i < 4; i++) set_clr(i, 1'b0);

    foreach (vq[n]) begin
      idle();
      ld[vq[n].inst]  = vq[n].ld;
      en[vq[n].inst]  = vq[n].en;
      dir[vq[n].inst] = vq[n].dir;
      d[vq[n].inst]   = 4'(vq[n].d);
      #1;
      check("vec_tc", vq[n].inst, gettc(vq[n].inst), vq[n].tc);
      tick();
      check("vec_q", vq[n].inst, getq(vq[n].inst), vq[n].q);
      check("vec_wrap", vq[n].inst, getwrap(vq[n].inst), vq[n].wrap);
      check("vec_satf", vq[n].inst, getsatf(vq[n].inst), vq[n].satf);
    end
    idle();

    // Clear between edges at Q=6, then the first edge counts from 0
    ld[0] = 1'b1; d[0] = 4'd6;
    tick();
    check("preload6_q", 0, getq(0), 6);
    idle();
    #2 set_clr(0, 1'b1);
    #1;
    check("async_q", 0, getq(0), 0);
    check("async_wrap", 0, getwrap(0), 0);
    check("async_satf", 0, getsatf(0), 0);
    set_clr(0, 1'b0);
    en[0] = 1'b1;
    tick();
    check("post_clr_q", 0, getq(0), 1);

    // Clear in the middle of a wrap pulse leaves no residue
    idle(); ld[0] = 1'b1; d[0] = 4'd7;
    tick();
    idle(); en[0] = 1'b1;
    tick();
    check("wrap_pulse", 0, getwrap(0), 1);
    #2 set_clr(0, 1'b1);
    #1;
    check("wrap_abort", 0, getwrap(0), 0);
    idle(); ld[0] = 1'b1; en[0] = 1'b1; d[0] = 4'd5;
    tick();
    check("clr_ignores_ld", 0, getq(0), 0);
    set_clr(0, 1'b0);
    idle();
    tick();
    check("no_residual_wrap", 0, getwrap(0), 0);

    // Clear drops a sticky saturation flag
    ld[2] = 1'b1; d[2] = 4'd9;
    tick();
    idle(); en[2] = 1'b1;
    tick();
    check("sat_set", 2, getsatf(2), 1);
    #2 set_clr(2, 1'b1);
    #1;
    check("sat_clr", 2, getsatf(2), 0);
    check("sat_clr_q", 2, getq(2), 0);
    set_clr(2, 1'b0);
    idle();
    tick();

    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        set_clr(i, $urandom_range(0, 40) == 0);
        ld[i]  = ($urandom_range(0, 7) == 0);
        en[i]  = ($urandom_range(0, 3) != 0);
        dir[i] = ($urandom_range(0, 1) == 1);
        d[i]   = 4'($urandom_range(0, 15));
      end
      #1;
      for (int i = 0; i < 4; i++) check("rnd_tc", i, gettc(i), model_tc(i));
      tick();
      for (int i = 0; i < 4; i++) begin
        check("rnd_q", i, getq(i), mq[i]);
        check("rnd_wrap", i, getwrap(i), mwrap[i]);
        check("rnd_satf", i, getsatf(i), msatf[i]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
